// File: rtl/bsg_age_req_tracker.sv
// bsg_age_req_tracker
//
// Tracks one outstanding request per requester slot and reports how long each
// one has been waiting, so that an external age-based arbiter can favour the
// oldest request.
//
// Ports:
//   clk_i      sole clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   v_i        per-slot new-request valid
//   ready_o    per-slot accept-ready (slot is empty)
//   reqs_o     pending-request vector to the arbiter
//   ts_o       per-slot age, slice i at [i*ts_width_p +: ts_width_p]
//   grants_i   grant vector from the arbiter
//   oldest_o   one-hot oldest pending slot (lowest index on ties), 0 if none
//   error_o    sticky protocol error (stray grant or multi-bit grant)
//   starve_o   some pending slot has a saturated age
//
// Optional feature: define BSG_AGE_REQ_TRACKER_STARVE_EN to enable starve_o;
// otherwise starve_o is tied low.

module bsg_age_req_tracker #(
  parameter int unsigned inputs_p   = 4,
  parameter int unsigned ts_width_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [inputs_p-1:0]              v_i,
  output logic [inputs_p-1:0]              ready_o,
  output logic [inputs_p-1:0]              reqs_o,
  output logic [inputs_p*ts_width_p-1:0]   ts_o,
  input  logic [inputs_p-1:0]              grants_i,
  output logic [inputs_p-1:0]              oldest_o,
  output logic                             error_o,
  output logic                             starve_o
);

  localparam logic [ts_width_p-1:0] AgeMax = '1;

  logic [inputs_p-1:0]   pending_q, pending_d;
  logic [ts_width_p-1:0] age_q [inputs_p];
  logic [ts_width_p-1:0] age_d [inputs_p];
  logic                  error_q, error_d;

  logic stray_grant;
  logic multi_grant;

  // Next-state: accept only happens on an empty slot and a grant only takes
  // effect on a pending slot, so the two can never collide on one slot.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      age_d[i] = age_q[i];
      if (v_i[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        age_d[i]     = '0;
      end else if (grants_i[i] && pending_q[i]) begin
        pending_d[i] = 1'b0;
        age_d[i]     = '0;
      end else if (pending_q[i] && (age_q[i] != AgeMax)) begin
        age_d[i] = age_q[i] + ts_width_p'(1);
      end
    end
  end

  assign stray_grant = |(grants_i & ~pending_q);
  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign multi_grant = |(grants_i & (grants_i - inputs_p'(1)));
  assign error_d     = error_q | stray_grant | multi_grant;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_q <= '0;
      error_q   <= 1'b0;
      for (int unsigned i = 0; i < inputs_p; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      error_q   <= error_d;
      for (int unsigned i = 0; i < inputs_p; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign ready_o = ~pending_q;
  assign reqs_o  = pending_q;
  assign error_o = error_q;

  always_comb begin
    ts_o = '0;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      ts_o[i*ts_width_p +: ts_width_p] = pending_q[i] ? age_q[i] : '0;
    end
  end

  // Strictly-greater compare while scanning upward keeps the lowest index on ties.
  logic                  oldest_found;
  logic [ts_width_p-1:0] oldest_age;

  always_comb begin
    oldest_o     = '0;
    oldest_found = 1'b0;
    oldest_age   = '0;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      if (pending_q[i] && (!oldest_found || (age_q[i] > oldest_age))) begin
        oldest_found = 1'b1;
        oldest_age   = age_q[i];
        oldest_o     = '0;
        oldest_o[i]  = 1'b1;
      end
    end
  end

`ifdef BSG_AGE_REQ_TRACKER_STARVE_EN
  always_comb begin
    starve_o = 1'b0;
    for (int unsigned i = 0; i < inputs_p; i++) begin
      if (pending_q[i] && (age_q[i] == AgeMax)) begin
        starve_o = 1'b1;
      end
    end
  end
`else
  assign starve_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_age_req_tracker.sv
module tb_bsg_age_req_tracker;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 4;
  localparam int          MAXA = 15;

`ifdef BSG_AGE_REQ_TRACKER_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   v_i = '0;
  logic [N-1:0]   ready_o;
  logic [N-1:0]   reqs_o;
  logic [N*W-1:0] ts_o;
  logic [N-1:0]   grants_i = '0;
  logic [N-1:0]   oldest_o;
  logic           error_o;
  logic           starve_o;

  always #5 clk = ~clk;

  bsg_age_req_tracker #(
    .inputs_p  (N),
    .ts_width_p(W)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .reqs_o   (reqs_o),
    .ts_o     (ts_o),
    .grants_i (grants_i),
    .oldest_o (oldest_o),
    .error_o  (error_o),
    .starve_o (starve_o)
  );

  typedef struct packed {
    logic [N-1:0]   reqs;
    logic [N-1:0]   ready;
    logic [N-1:0]   oldest;
    logic [N*W-1:0] ts;
    logic           error;
    logic           starve;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [N-1:0] m_pend;
  int           m_age [N];
  logic         m_err;

  task automatic model_clear();
    m_pend = '0;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_next(input logic [N-1:0] v, input logic [N-1:0] g);
    logic [N-1:0] np;
    np = m_pend;
    if ($countones(g) > 1) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (g[i] && !m_pend[i]) m_err = 1'b1;
      if (v[i] && !m_pend[i]) begin
        np[i] = 1'b1;
        m_age[i] = 0;
      end else if (g[i] && m_pend[i]) begin
        np[i] = 1'b0;
        m_age[i] = 0;
      end else if (m_pend[i]) begin
        m_age[i] = (m_age[i] >= MAXA) ? MAXA : m_age[i] + 1;
      end
    end
    m_pend = np;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   best;
    int   sel;
    e    = '0;
    best = -1;
    sel  = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_age[i] > best) best = m_age[i];
    for (int i = 0; i < N; i++)
      if (sel < 0 && m_pend[i] && m_age[i] == best) sel = i;
    e.reqs  = m_pend;
    e.ready = ~m_pend;
    if (sel >= 0) e.oldest[sel] = 1'b1;
    for (int i = 0; i < N; i++)
      if (m_pend[i]) e.ts[i*W +: W] = 4'(m_age[i]);
    e.error = m_err;
    e.starve = 1'b0;
    if (STARVE_ON)
      for (int i = 0; i < N; i++)
        if (m_pend[i] && m_age[i] == MAXA) e.starve = 1'b1;
    return e;
  endfunction

  // Scoreboard consumer: one expected entry per clocked step.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {reqs_o, ready_o, oldest_o, ts_o, error_o, starve_o};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got reqs=%b ready=%b oldest=%b ts=%h err=%b starve=%b, want reqs=%b ready=%b oldest=%b ts=%h err=%b starve=%b",
                 $time, mon_a.reqs, mon_a.ready, mon_a.oldest, mon_a.ts, mon_a.error,
                 mon_a.starve, mon_e.reqs, mon_e.ready, mon_e.oldest, mon_e.ts,
                 mon_e.error, mon_e.starve);
      end
    end
  end

  // Drive one cycle of stimulus, predict the post-edge outputs, return at negedge+1.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] g);
    v_i      = v;
    grants_i = g;
    model_next(v, g);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    v_i      = '0;
    grants_i = '0;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({ready_o, reqs_o, ts_o, oldest_o, error_o, starve_o} !==
        {4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b reqs=%b ts=%h oldest=%b err=%b starve=%b, want 1111 0000 0000 0000 0 0",
               ready_o, reqs_o, ts_o, oldest_o, error_o, starve_o);
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_single_accept();
    do_reset();
    step(4'b0001, '0);
    checks++;
    if ({reqs_o, ready_o, ts_o[3:0]} !== {4'b0001, 4'b1110, 4'd0}) begin
      errors++;
      $display("FAIL single_accept: got reqs=%b ready=%b ts0=%0d, want 0001 1110 0",
               reqs_o, ready_o, ts_o[3:0]);
    end
    idle(3);
    checks++;
    if (ts_o[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL single_age3: got ts0=%0d, want 3", ts_o[3:0]);
    end
  endtask

  task automatic test_oldest_grant();
    do_reset();
    step(4'b0001, '0);  // cycle 0: slot0 age 0
    idle(1);            // cycle 1
    step(4'b0100, '0);  // cycle 2: slot2 age 0
    idle(2);            // cycle 4
    checks++;
    if ({oldest_o, ts_o[3:0], ts_o[11:8]} !== {4'b0001, 4'd4, 4'd2}) begin
      errors++;
      $display("FAIL oldest_pick: got oldest=%b ts0=%0d ts2=%0d, want 0001 4 2",
               oldest_o, ts_o[3:0], ts_o[11:8]);
    end
    step('0, 4'b0001);
    checks++;
    if ({reqs_o, oldest_o, ready_o[0], error_o} !== {4'b0100, 4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL grant_retire: got reqs=%b oldest=%b ready0=%b err=%b, want 0100 0100 1 0",
               reqs_o, oldest_o, ready_o[0], error_o);
    end
  endtask

  task automatic test_tie();
    do_reset();
    step(4'b1010, '0);
    idle(1);
    checks++;
    if ({oldest_o, ts_o[7:4], ts_o[15:12]} !== {4'b0010, 4'd1, 4'd1}) begin
      errors++;
      $display("FAIL tie_lowest: got oldest=%b ts1=%0d ts3=%0d, want 0010 1 1",
               oldest_o, ts_o[7:4], ts_o[15:12]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(4'b0001, '0);
    for (int c = 1; c <= 20; c++) begin
      step('0, '0);
      if (c >= MAXA) begin
        checks++;
        if ({ts_o[3:0], starve_o} !== {4'd15, STARVE_ON}) begin
          errors++;
          $display("FAIL saturate c=%0d: got ts0=%0d starve=%b, want 15 %b",
                   c, ts_o[3:0], starve_o, STARVE_ON);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(4'b0011, '0);
    step(4'b0100, 4'b0001);  // accept slot2 and retire slot0 together
    step(4'b0001, 4'b0010);  // reaccept slot0, retire slot1
    step(4'b0100, '0);       // v on pending slot2 is not an accept
    checks++;
    if ({reqs_o, error_o, ts_o[11:8]} !== {4'b0101, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL back_to_back: got reqs=%b err=%b ts2=%0d, want 0101 0 2",
               reqs_o, error_o, ts_o[11:8]);
    end
  endtask

  task automatic test_errors();
    do_reset();
    step('0, 4'b0100);
    checks++;
    if ({error_o, reqs_o} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL stray_grant: got err=%b reqs=%b, want 1 0000", error_o, reqs_o);
    end
    idle(3);
    checks++;
    if (error_o !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got err=%b, want 1", error_o);
    end
    do_reset();
    step(4'b0011, '0);
    step('0, 4'b0011);
    checks++;
    if ({error_o, reqs_o, ready_o} !== {1'b1, 4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL multi_grant: got err=%b reqs=%b ready=%b, want 1 0000 1111",
               error_o, reqs_o, ready_o);
    end
  endtask

  task automatic test_async_reset();
    step(4'b0111, '0);  // error_o still set from the previous task
    idle(1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({ready_o, reqs_o, ts_o, oldest_o, error_o, starve_o} !==
        {4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got ready=%b reqs=%b ts=%h oldest=%b err=%b, want 1111 0000 0000 0000 0",
               ready_o, reqs_o, ts_o, oldest_o, error_o);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);
    checks++;
    if ({reqs_o, ready_o} !== {4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL after_reset: got reqs=%b ready=%b, want 0000 1111", reqs_o, ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_accept();
    test_oldest_grant();
    test_tie();
    test_saturate();
    test_back_to_back();
    test_errors();
    test_async_reset();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
